pos_tracker: RTL
================

POS_TRACKER -- requirements
Module: pos_tracker

Interface
REQ-001 Parameter CNT_INIT, 8'd128: value loaded into each live counter on reset and on clear.
REQ-002 Parameter WRAP, 0: 0 = counters saturate at 0/255; 1 = counters wrap modulo 256.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 xa, xb  input  1 each  X-axis quadrature pair, asynchronous to clk.
REQ-006 ya, yb  input  1 each  Y-axis quadrature pair, asynchronous to clk.
REQ-007 clear  input  1  synchronous one-cycle pulse; reloads both live counters.
REQ-008 snap  input  1  synchronous one-cycle pulse, asserted by the downstream I2C read slave on bus START; captures a coherent snapshot.
REQ-009 x_pos  output  8  snapshot X count, held stable between snaps.
REQ-010 y_pos  output  8  snapshot Y count, held stable between snaps.
REQ-011 status  output  8  snapshot status byte, bit map per REQ-020.

Function
REQ-012 Each quadrature input SHALL pass a 2-FF synchronizer before any use.
REQ-013 Each axis SHALL decode 4x: synced {a,b} sequence 00->01->11->10->00 = +1, reverse = -1, no change = 0.
REQ-014 A transition changing both bits in one sample SHALL cause no count and SHALL set that axis's error flag.
REQ-015 Pin change to live-counter update latency SHALL be exactly 3 clk cycles (2 sync + 1 decode/count).
REQ-016 WRAP=0: +1 at 255 holds 255, -1 at 0 holds 0; the blocked step sets the axis limit flag.
REQ-017 WRAP=1: 255+1 -> 0, 0-1 -> 255; each wrap sets the axis limit flag.
REQ-018 Any accepted step SHALL set the axis moved flag and record direction (1 = +1, 0 = -1).
REQ-019 Moved, limit and error flags are sticky until the next snap.
REQ-020 Status bits: [0] x_moved, [1] y_moved, [2] x_limit, [3] y_limit, [4] x_dir, [5] y_dir, [6] quad_err (X or Y), [7] valid (at least one snap since reset, included in the current capture).
REQ-021 On snap in cycle N: x_pos/y_pos/status SHALL show pre-edge live values from cycle N+1; sticky flags SHALL clear at the same edge; dir bits are not cleared.
REQ-022 Outputs SHALL NOT change except on a snap edge or reset.
REQ-023 Snap and step in the same cycle: capture takes the pre-step count and flags; the step updates the live counter and re-sets its flags for the next window.
REQ-024 Clear and step in the same cycle: clear wins and the step is discarded; flags still record the step.
REQ-025 Clear and snap in the same cycle: capture takes the pre-clear value; the live counter reloads to CNT_INIT.
REQ-026 The first decode cycle after reset release SHALL only prime the previous-state register: no count, no error.

Reset
REQ-027 While rst is high: x_pos, y_pos, status = 0; live counters = CNT_INIT; sync registers, flags, dir and valid = 0; prime pending.
REQ-028 rst asserted mid-stream SHALL abort immediately, with no partial count retained.

Structure
REQ-029 Shared package pos_pkg SHALL hold the status bit-index constants and the default CNT_INIT, so the I2C slave and its bench use the same map.
REQ-030 Per-axis logic (sync, decode, counter, sticky flags) SHALL be one sub-module, quad_axis, instantiated twice; pos_tracker holds snapshot registers and status packing.

Verification
REQ-031 Reset, 4 steps +1 on X, snap -> x_pos=132, y_pos=128, status=8'b1001_0001.
REQ-032 WRAP=0, clear, then 130 steps +1 on Y, snap -> y_pos=255, status[3]=1, status[5]=1.
REQ-033 WRAP=1, X counter at 0, one -1 step, snap -> x_pos=255, status[2]=1, status[4]=0.
REQ-034 X pins 00->11 in one sample, snap -> x_pos unchanged, status[6]=1; second snap with no activity -> status[6]=0, status[0]=0.
REQ-035 Step whose count edge coincides with snap -> capture shows old value; next snap shows +1 with moved flag set.
REQ-036 Pins at 11 across reset release -> no count and no error; rst pulsed mid-sequence -> all outputs 0 and counters 128.

Source files
------------

// File: rtl/pos_pkg.sv
// Shared definitions for the position tracker: status bit map, default counter
// preload and the quadrature step decoder used by each axis.
package pos_pkg;

  localparam logic [7:0] CNT_INIT_DEFAULT = 8'd128;

  localparam int ST_X_MOVED = 0;
  localparam int ST_Y_MOVED = 1;
  localparam int ST_X_LIMIT = 2;
  localparam int ST_Y_LIMIT = 3;
  localparam int ST_X_DIR   = 4;
  localparam int ST_Y_DIR   = 5;
  localparam int ST_QERR    = 6;
  localparam int ST_VALID   = 7;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

  // Maps the Gray-coded {a,b} pair onto its position in the 00-01-11-10 cycle.
  function automatic logic [1:0] quad_phase(input logic [1:0] ab);
    quad_phase = {ab[1], ab[1] ^ ab[0]};
  endfunction

  function automatic step_e quad_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] delta;
    delta = quad_phase(cur_ab) - quad_phase(prev_ab);
    case (delta)
      2'd1:    quad_step = STEP_UP;
      2'd3:    quad_step = STEP_DN;
      2'd2:    quad_step = STEP_ERR;
      default: quad_step = STEP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/quad_axis.sv
// One quadrature axis: input synchronizer, 4x decoder, saturating or wrapping
// counter and the sticky moved/limit/error flags that are cleared by a snap.
module quad_axis
  import pos_pkg::*;
#(
  parameter logic [7:0] CNT_INIT = CNT_INIT_DEFAULT,
  parameter bit         WRAP     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_i,
  input  logic       b_i,
  input  logic       clear_i,
  input  logic       snap_i,
  output logic [7:0] cnt_o,
  output logic       moved_o,
  output logic       limit_o,
  output logic       dir_o,
  output logic       err_o
);

  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] prev_q;
  logic [1:0] fill_q;
  logic       primed_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       moved_q;
  logic       moved_d;
  logic       limit_q;
  logic       limit_d;
  logic       dir_q;
  logic       dir_d;
  logic       err_q;
  logic       err_d;
  step_e      step;
  logic       at_edge;
  logic       is_step;

  always_comb begin
    step    = primed_q ? quad_step(prev_q, sync2_q) : STEP_NONE;
    cnt_d   = cnt_q;
    at_edge = 1'b0;
    case (step)
      STEP_UP: begin
        at_edge = (cnt_q == 8'hFF);
        if (!at_edge || WRAP) cnt_d = cnt_q + 8'd1;
      end
      STEP_DN: begin
        at_edge = (cnt_q == 8'h00);
        if (!at_edge || WRAP) cnt_d = cnt_q - 8'd1;
      end
      default: ;
    endcase
    // A same-cycle clear discards the count but the flags below still see the step.
    if (clear_i) cnt_d = CNT_INIT;
    is_step = (step == STEP_UP) || (step == STEP_DN);
    moved_d = (moved_q & ~snap_i) | is_step;
    limit_d = (limit_q & ~snap_i) | at_edge;
    err_d   = (err_q & ~snap_i) | (step == STEP_ERR);
    dir_d   = is_step ? (step == STEP_UP) : dir_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      prev_q   <= 2'b00;
      fill_q   <= 2'b00;
      primed_q <= 1'b0;
      cnt_q    <= CNT_INIT;
      moved_q  <= 1'b0;
      limit_q  <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= {a_i, b_i};
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      // Priming waits until sync2 holds a real pin sample, not the reset zeros.
      fill_q   <= {fill_q[0], 1'b1};
      primed_q <= primed_q | fill_q[1];
      cnt_q    <= cnt_d;
      moved_q  <= moved_d;
      limit_q  <= limit_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign moved_o = moved_q;
  assign limit_o = limit_q;
  assign dir_o   = dir_q;
  assign err_o   = err_q;

endmodule

// File: rtl/pos_tracker.sv
// Two-axis quadrature position tracker with a snapshot register set that an
// I2C read slave captures coherently on bus START.
module pos_tracker
  import pos_pkg::*;
#(
  parameter logic [7:0] CNT_INIT = CNT_INIT_DEFAULT,
  parameter bit         WRAP     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       xa,
  input  logic       xb,
  input  logic       ya,
  input  logic       yb,
  input  logic       clear,
  input  logic       snap,
  output logic [7:0] x_pos,
  output logic [7:0] y_pos,
  output logic [7:0] status
);

  logic [1:0] pin_a;
  logic [1:0] pin_b;
  logic [7:0] cnt [2];
  logic [1:0] moved;
  logic [1:0] limit;
  logic [1:0] dir;
  logic [1:0] err;
  logic [7:0] status_live;
  logic [7:0] x_pos_q;
  logic [7:0] y_pos_q;
  logic [7:0] status_q;

  assign pin_a = {ya, xa};
  assign pin_b = {yb, xb};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      quad_axis #(
        .CNT_INIT(CNT_INIT),
        .WRAP    (WRAP)
      ) u_axis (
        .clk    (clk),
        .rst    (rst),
        .a_i    (pin_a[gi]),
        .b_i    (pin_b[gi]),
        .clear_i(clear),
        .snap_i (snap),
        .cnt_o  (cnt[gi]),
        .moved_o(moved[gi]),
        .limit_o(limit[gi]),
        .dir_o  (dir[gi]),
        .err_o  (err[gi])
      );
    end
  endgenerate

  always_comb begin
    status_live             = 8'h00;
    status_live[ST_X_MOVED] = moved[0];
    status_live[ST_Y_MOVED] = moved[1];
    status_live[ST_X_LIMIT] = limit[0];
    status_live[ST_Y_LIMIT] = limit[1];
    status_live[ST_X_DIR]   = dir[0];
    status_live[ST_Y_DIR]   = dir[1];
    status_live[ST_QERR]    = |err;
    // Every capture happens on a snap, so the captured byte is always valid.
    status_live[ST_VALID]   = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_pos_q  <= 8'h00;
      y_pos_q  <= 8'h00;
      status_q <= 8'h00;
    end else if (snap) begin
      x_pos_q  <= cnt[0];
      y_pos_q  <= cnt[1];
      status_q <= status_live;
    end
  end

  assign x_pos  = x_pos_q;
  assign y_pos  = y_pos_q;
  assign status = status_q;

endmodule
